// File: rtl/monitor_forma_onda.sv
// -----------------------------------------------------------------------------
// monitor_forma_onda
// Measures every complete period of the 1-bit waveform f: length of the high
// run, length of the low run and their sum, all in Clock cycles. It declares
// lock after LOCK_N identical consecutive periods and flags period changes
// that happen while locked.
//
// Ports
//   Clock       : system clock, all logic on the rising edge
//   Reset       : synchronous, active-high, highest priority
//   f           : waveform under measurement
//   Habilita    : measurement enable
//   AltoCiclos  : high-run length of the last completed period
//   BaixoCiclos : low-run length of the last completed period
//   Periodo     : AltoCiclos + BaixoCiclos (one extra bit, never truncated)
//   Valido      : one-cycle pulse, the three measurements were just updated
//   Travado     : period is stable (locked)
//   Erro        : sticky, the period changed while locked
//   Overflow    : sticky, a run counter saturated
// -----------------------------------------------------------------------------
module monitor_forma_onda #(
   parameter int LARGURA = 8,
   parameter int LOCK_N  = 3
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               f,
   input  logic               Habilita,
   output logic [LARGURA-1:0] AltoCiclos,
   output logic [LARGURA-1:0] BaixoCiclos,
   output logic [LARGURA:0]   Periodo,
   output logic               Valido,
   output logic               Travado,
   output logic               Erro,
   output logic               Overflow
);

   localparam int                 EQW      = $clog2(LOCK_N) + 1;
   localparam logic [LARGURA-1:0] CONT_MAX = '1;
   localparam logic [LARGURA-1:0] CONT_UM  = LARGURA'(1);
   localparam logic [EQW-1:0]     EQ_ALVO  = EQW'(LOCK_N - 1);

   typedef enum logic [1:0] {IDLE, ALTO, BAIXO} estado_t;

   estado_t            estado_q, estado_d;
   logic               f_q;
   logic               amostra_ok_q;
   logic               armado_q, armado_d;
   logic [LARGURA-1:0] cont_alto_q, cont_alto_d;
   logic [LARGURA-1:0] cont_baixo_q, cont_baixo_d;
   logic               sat_q, sat_d;
   logic [EQW-1:0]     eq_q, eq_d, eq_inc;
   logic               tem_ant_q, tem_ant_d;
   logic [LARGURA-1:0] alto_q, alto_d;
   logic [LARGURA-1:0] baixo_q, baixo_d;
   logic [LARGURA:0]   periodo_q, periodo_d, periodo_novo;
   logic               valido_q, valido_d;
   logic               travado_q, travado_d;
   logic               erro_q, erro_d;
   logic               overflow_q, overflow_d;

   always_comb begin
      estado_d     = estado_q;
      armado_d     = armado_q;
      cont_alto_d  = cont_alto_q;
      cont_baixo_d = cont_baixo_q;
      sat_d        = sat_q;
      eq_d         = eq_q;
      tem_ant_d    = tem_ant_q;
      alto_d       = alto_q;
      baixo_d      = baixo_q;
      periodo_d    = periodo_q;
      valido_d     = 1'b0;
      travado_d    = travado_q;
      erro_d       = erro_q;
      overflow_d   = overflow_q;
      periodo_novo = {1'b0, cont_alto_q} + {1'b0, cont_baixo_q};
      eq_inc       = (eq_q == EQ_ALVO) ? eq_q : eq_q + 1'b1;

      if (!Habilita) begin
         // Abandon the period in progress and forget the predecessor, but
         // keep the last published measurements and sticky flags visible.
         estado_d     = IDLE;
         armado_d     = 1'b0;
         cont_alto_d  = '0;
         cont_baixo_d = '0;
         sat_d        = 1'b0;
         eq_d         = '0;
         tem_ant_d    = 1'b0;
         travado_d    = 1'b0;
      end else begin
         unique case (estado_q)
            IDLE: begin
               // f_q holds a genuine sample only one cycle after reset, so
               // the reset value of f_q can never be mistaken for a low run.
               // A rising edge counts only after a real low has been seen.
               if (amostra_ok_q) begin
                  if (!f_q) begin
                     armado_d = 1'b1;
                  end else if (armado_q) begin
                     estado_d    = ALTO;
                     cont_alto_d = CONT_UM;
                     armado_d    = 1'b0;
                     sat_d       = 1'b0;
                  end
               end
            end
            ALTO: begin
               if (f_q) begin
                  if (cont_alto_q == CONT_MAX) begin
                     sat_d      = 1'b1;
                     overflow_d = 1'b1;
                  end else begin
                     cont_alto_d = cont_alto_q + 1'b1;
                  end
               end else begin
                  estado_d     = BAIXO;
                  cont_baixo_d = CONT_UM;
               end
            end
            BAIXO: begin
               if (!f_q) begin
                  if (cont_baixo_q == CONT_MAX) begin
                     sat_d      = 1'b1;
                     overflow_d = 1'b1;
                  end else begin
                     cont_baixo_d = cont_baixo_q + 1'b1;
                  end
               end else begin
                  // Rising edge closes the period: publish it and start the
                  // next high run in the same cycle.
                  valido_d     = 1'b1;
                  alto_d       = cont_alto_q;
                  baixo_d      = cont_baixo_q;
                  periodo_d    = periodo_novo;
                  tem_ant_d    = 1'b1;
                  estado_d     = ALTO;
                  cont_alto_d  = CONT_UM;
                  cont_baixo_d = '0;
                  sat_d        = 1'b0;
                  if (sat_q) begin
                     // A clipped measurement is not trustworthy for lock,
                     // and is not treated as a genuine period change either.
                     eq_d      = '0;
                     travado_d = 1'b0;
                  end else if (tem_ant_q && (periodo_novo == periodo_q)) begin
                     eq_d      = eq_inc;
                     travado_d = (eq_inc == EQ_ALVO);
                  end else begin
                     if (travado_q) begin
                        erro_d = 1'b1;
                     end
                     travado_d = 1'b0;
                     eq_d      = '0;
                  end
               end
            end
            default: estado_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         estado_q     <= IDLE;
         f_q          <= 1'b0;
         amostra_ok_q <= 1'b0;
         armado_q     <= 1'b0;
         cont_alto_q  <= '0;
         cont_baixo_q <= '0;
         sat_q        <= 1'b0;
         eq_q         <= '0;
         tem_ant_q    <= 1'b0;
         alto_q       <= '0;
         baixo_q      <= '0;
         periodo_q    <= '0;
         valido_q     <= 1'b0;
         travado_q    <= 1'b0;
         erro_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         f_q          <= f;
         amostra_ok_q <= 1'b1;
         armado_q     <= armado_d;
         cont_alto_q  <= cont_alto_d;
         cont_baixo_q <= cont_baixo_d;
         sat_q        <= sat_d;
         eq_q         <= eq_d;
         tem_ant_q    <= tem_ant_d;
         alto_q       <= alto_d;
         baixo_q      <= baixo_d;
         periodo_q    <= periodo_d;
         valido_q     <= valido_d;
         travado_q    <= travado_d;
         erro_q       <= erro_d;
         overflow_q   <= overflow_d;
      end
   end

   assign AltoCiclos  = alto_q;
   assign BaixoCiclos = baixo_q;
   assign Periodo     = periodo_q;
   assign Valido      = valido_q;
   assign Travado     = travado_q;
   assign Erro        = erro_q;
   assign Overflow    = overflow_q;

endmodule

// File: tb/tb_monitor_forma_onda.sv
// -----------------------------------------------------------------------------
// Testbench for monitor_forma_onda. Stimulus is built from whole periods
// (high run, low run); a period-level reference model predicts every
// publication and pushes it into a scoreboard queue. A monitor on the falling
// edge pops and compares whenever Valido is seen.
// -----------------------------------------------------------------------------
module tb_monitor_forma_onda;

   localparam int LARGURA = 8;
   localparam int LOCK_N  = 3;
   localparam int MAXC    = (1 << LARGURA) - 1;

   logic               Clock = 1'b0;
   logic               Reset = 1'b1;
   logic               f = 1'b0;
   logic               Habilita = 1'b1;
   logic [LARGURA-1:0] AltoCiclos;
   logic [LARGURA-1:0] BaixoCiclos;
   logic [LARGURA:0]   Periodo;
   logic               Valido;
   logic               Travado;
   logic               Erro;
   logic               Overflow;

   monitor_forma_onda #(.LARGURA(LARGURA), .LOCK_N(LOCK_N)) dut (
      .Clock(Clock), .Reset(Reset), .f(f), .Habilita(Habilita),
      .AltoCiclos(AltoCiclos), .BaixoCiclos(BaixoCiclos), .Periodo(Periodo),
      .Valido(Valido), .Travado(Travado), .Erro(Erro), .Overflow(Overflow)
   );

   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc++;

   typedef struct {
      int alto;
      int baixo;
      int periodo;
      int trav;
      int erro;
      int ovf;
      int ciclo;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   // reference model state (period level)
   int m_prev, m_eq, m_last_a, m_last_b, m_last_p;
   bit m_tem, m_trav, m_erro, m_ovf;
   // stimulus bookkeeping
   bit last_f, armado, counting, tem_pend;
   int cur_h, pend_h, pend_l;

   task automatic chk(string nome, int got, int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, got, expv, cyc);
      end
   endtask

   task automatic model_clear_lock();
      m_tem  = 1'b0;
      m_eq   = 0;
      m_trav = 1'b0;
   endtask

   // One completed period with the given raw run lengths; Valido expected at ciclo.
   task automatic model_pub(int h, int l, int ciclo);
      exp_t e;
      int a, b, p;
      bit sat;
      a   = (h > MAXC) ? MAXC : h;
      b   = (l > MAXC) ? MAXC : l;
      sat = (h > MAXC) || (l > MAXC);
      p   = a + b;
      if (sat) begin
         m_ovf  = 1'b1;
         m_eq   = 0;
         m_trav = 1'b0;
      end else if (m_tem && p == m_prev) begin
         if (m_eq < LOCK_N - 1) m_eq++;
         m_trav = (m_eq == LOCK_N - 1);
      end else begin
         if (m_trav) m_erro = 1'b1;
         m_trav = 1'b0;
         m_eq   = 0;
      end
      m_prev   = p;
      m_tem    = 1'b1;
      m_last_a = a;
      m_last_b = b;
      m_last_p = p;
      e.alto = a; e.baixo = b; e.periodo = p;
      e.trav = m_trav; e.erro = m_erro; e.ovf = m_ovf; e.ciclo = ciclo;
      sb.push_back(e);
   endtask

   task automatic tick(bit v);
      f = v;
      @(posedge Clock);
      #1;
   endtask

   task automatic send_high(int n);
      if (!last_f) begin
         // rising edge driven now: closes the pending period two cycles later
         if (tem_pend) model_pub(pend_h, pend_l, cyc + 2);
         counting = armado;
         cur_h    = n;
      end else begin
         counting = 1'b0;
      end
      tem_pend = 1'b0;
      last_f   = 1'b1;
      repeat (n) tick(1'b1);
   endtask

   task automatic send_low(int n);
      if (last_f && counting) begin
         pend_h   = cur_h;
         pend_l   = n;
         tem_pend = 1'b1;
      end
      counting = 1'b0;
      armado   = 1'b1;
      last_f   = 1'b0;
      repeat (n) tick(1'b0);
   endtask

   task automatic periods(int h, int l, int n);
      repeat (n) begin
         send_high(h);
         send_low(l);
      end
   endtask

   task automatic do_reset(bit fval);
      Reset = 1'b1;
      tick(fval);
      chk("reset_alto", AltoCiclos, 0);
      chk("reset_baixo", BaixoCiclos, 0);
      chk("reset_periodo", Periodo, 0);
      chk("reset_valido", Valido, 0);
      chk("reset_travado", Travado, 0);
      chk("reset_erro", Erro, 0);
      chk("reset_overflow", Overflow, 0);
      tick(fval);
      chk("pendentes_antes_reset", sb.size(), 0);
      sb.delete();
      model_clear_lock();
      m_erro = 1'b0; m_ovf = 1'b0;
      m_last_a = 0; m_last_b = 0; m_last_p = 0; m_prev = 0;
      last_f = 1'b1; armado = 1'b0; counting = 1'b0; tem_pend = 1'b0;
      Reset = 1'b0;
   endtask

   task automatic hab_gap(int n);
      Habilita = 1'b0;
      counting = 1'b0; tem_pend = 1'b0; armado = 1'b0;
      model_clear_lock();
      repeat (n) tick(1'b0);
      chk("gap_travado", Travado, 0);
      chk("gap_valido", Valido, 0);
      chk("gap_periodo", Periodo, m_last_p);
      chk("gap_alto", AltoCiclos, m_last_a);
      chk("gap_erro", Erro, m_erro);
      Habilita = 1'b1;
      last_f = 1'b0;
   endtask

   // monitor: compares every publication against the scoreboard
   always @(negedge Clock) begin
      if (Valido === 1'b1) begin
         if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL valido_inesperado: got Valido=1 expected 0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("pub cycle=%0d alto=%0d baixo=%0d periodo=%0d trav=%0d erro=%0d ovf=%0d",
                     cyc, AltoCiclos, BaixoCiclos, Periodo, Travado, Erro, Overflow);
            chk("ciclo_valido", cyc, e.ciclo);
            chk("alto", AltoCiclos, e.alto);
            chk("baixo", BaixoCiclos, e.baixo);
            chk("periodo", Periodo, e.periodo);
            chk("travado", Travado, e.trav);
            chk("erro", Erro, e.erro);
            chk("overflow", Overflow, e.ovf);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // f high at reset release: partial first high run is ignored
      do_reset(1'b1);
      send_high(4);
      send_low(2);
      periods(6, 2, 5);
      // change of period after lock
      periods(5, 2, 4);
      send_high(5);
      // enable gap while locked
      hab_gap(10);
      send_low(3);
      periods(6, 2, 4);
      send_high(3);
      // randomized runs, repeated to exercise locking and errors
      send_low(2);
      repeat (25) begin
         int h, l, r;
         h = $urandom_range(1, 12);
         l = $urandom_range(1, 12);
         r = $urandom_range(1, 5);
         periods(h, l, r);
      end
      send_high(3);
      // saturating high run
      send_low(3);
      send_high(300);
      send_low(3);
      periods(4, 4, 3);
      send_high(4);
      // reset in the middle of a high run
      send_low(3);
      send_high(5);
      do_reset(1'b1);
      send_high(3);
      send_low(2);
      periods(6, 2, 4);
      send_high(3);
      tick(1'b1);
      tick(1'b1);
      chk("pendentes_final", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
